// File: rtl/weight_loader_if.sv
// Handshake bundle between the weight stream source, the loader
// and the downstream weight register.
interface weight_loader_if #(
  parameter int NUM          = 16,
  parameter int BEAT_WORDS   = 2,
  parameter int WEIGHT_WIDTH = 8
);
  logic                                    in_valid;
  logic                                    in_ready;
  logic [BEAT_WORDS-1:0][WEIGHT_WIDTH-1:0] in_data;
  logic                                    w_valid;
  logic                                    w_ready;
  logic [NUM-1:0][WEIGHT_WIDTH-1:0]        w_out;

  modport master (
    output in_valid,
    output in_data,
    output w_ready,
    input  in_ready,
    input  w_valid,
    input  w_out
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  w_ready,
    output in_ready,
    output w_valid,
    output w_out
  );
endinterface

// File: rtl/weight_loader.sv
// Assembles a weight matrix from narrow beats and holds it
// until the downstream register takes it.
module weight_loader #(
  parameter int DIM_ROW2     = 4,
  parameter int DIM_COL2     = 4,
  parameter int WEIGHT_WIDTH = 8,
  parameter int BEAT_WORDS   = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  weight_loader_if.slave bus,
  output logic [$clog2(DIM_ROW2*DIM_COL2/BEAT_WORDS+1)-1:0] beat_cnt
);
  localparam int NUM   = DIM_ROW2 * DIM_COL2;
  localparam int BEATS = NUM / BEAT_WORDS;
  localparam int CW    = $clog2(BEATS + 1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t                           state_q;
  state_t                           state_d;
  logic [CW-1:0]                    cnt_q;
  logic [CW-1:0]                    cnt_d;
  logic [NUM-1:0][WEIGHT_WIDTH-1:0] mem_q;
  logic                             accept;
  logic                             last;

  assign accept = bus.in_valid & (state_q == FILL) & ~clear;
  assign last   = (cnt_q == CW'(BEATS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = FILL;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (accept) begin
            if (last) begin
              state_d = FULL;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        FULL: begin
          if (bus.w_ready) state_d = FILL;
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Only the lanes of the current beat are written; the rest hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else if (accept) begin
      for (int k = 0; k < BEATS; k++) begin
        if (cnt_q == CW'(k)) begin
          for (int j = 0; j < BEAT_WORDS; j++) begin
            mem_q[k*BEAT_WORDS+j] <= bus.in_data[j];
          end
        end
      end
    end
  end

  assign bus.in_ready = (state_q == FILL);
  assign bus.w_valid  = (state_q == FULL);
  assign bus.w_out    = mem_q;
  assign beat_cnt     = cnt_q;

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader at default geometry
// (16 elements, 2 words per beat, 8 beats).
module tb_weight_loader;
  localparam int NUM = 16;
  localparam int BW  = 2;
  localparam int WW  = 8;

  logic clk;
  logic rst_n;
  logic clear;
  logic [3:0] beat_cnt;
  logic [NUM-1:0][WW-1:0] exp_w;

  int checks;
  int errors;

  weight_loader_if #(
    .NUM(NUM), .BEAT_WORDS(BW), .WEIGHT_WIDTH(WW)
  ) bus ();

  weight_loader #(
    .DIM_ROW2(4), .DIM_COL2(4),
    .WEIGHT_WIDTH(WW), .BEAT_WORDS(BW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clear(clear),
    .bus(bus.slave),
    .beat_cnt(beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input int lo);
    bus.in_valid   = 1'b1;
    bus.in_data[0] = WW'(lo);
    bus.in_data[1] = WW'(lo + 1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.w_ready  = 1'b0;
    cyc();
    cyc();
    exp_w = '0;
    checks++;
    if (bus.w_out !== exp_w) begin
      errors++;
      $display("FAIL reset_w_out got=%h want=%h", bus.w_out, exp_w);
    end
    checks++;
    if (bus.w_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_hs got v=%b r=%b want v=0 r=1",
               bus.w_valid, bus.in_ready);
    end
    checks++;
    if (beat_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_cnt got=%0d want=0", beat_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_full_load();
    for (int k = 0; k < 8; k++) begin
      drive_beat(2 * k);
      cyc();
      exp_w[2*k]   = WW'(2 * k);
      exp_w[2*k+1] = WW'(2 * k + 1);
      checks++;
      if (beat_cnt !== 4'((k + 1) % 8)) begin
        errors++;
        $display("FAIL load_cnt beat=%0d got=%0d want=%0d",
                 k, beat_cnt, (k + 1) % 8);
      end
      checks++;
      if (bus.w_valid !== (k == 7)) begin
        errors++;
        $display("FAIL load_valid beat=%0d got=%b want=%b",
                 k, bus.w_valid, (k == 7));
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.w_out !== exp_w) begin
      errors++;
      $display("FAIL load_w_out got=%h want=%h", bus.w_out, exp_w);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_ready got=%b want=0", bus.in_ready);
    end
  endtask

  task automatic test_backpressure();
    bus.in_valid = 1'b1;
    bus.in_data  = {8'hFF, 8'hFF};
    bus.w_ready  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if (bus.w_out !== exp_w || bus.w_valid !== 1'b1 ||
          beat_cnt !== 4'd0) begin
        errors++;
        $display("FAIL bp_hold c=%0d v=%b cnt=%0d w=%h want v=1 cnt=0 w=%h",
                 i, bus.w_valid, beat_cnt, bus.w_out, exp_w);
      end
    end
    bus.in_valid = 1'b0;
    bus.w_ready  = 1'b1;
    cyc();
    bus.w_ready  = 1'b0;
    checks++;
    if (bus.w_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got v=%b r=%b want v=0 r=1",
               bus.w_valid, bus.in_ready);
    end
    checks++;
    if (bus.w_out !== exp_w) begin
      errors++;
      $display("FAIL bp_retain got=%h want=%h", bus.w_out, exp_w);
    end
    bus.w_ready = 1'b1;
    cyc();
    bus.w_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.w_valid !== 1'b0 ||
        beat_cnt !== 4'd0) begin
      errors++;
      $display("FAIL idle_wready r=%b v=%b cnt=%0d want r=1 v=0 cnt=0",
               bus.in_ready, bus.w_valid, beat_cnt);
    end
  endtask

  task automatic test_abort();
    for (int k = 0; k < 3; k++) begin
      drive_beat(100 + 2 * k);
      cyc();
      exp_w[2*k]   = WW'(100 + 2 * k);
      exp_w[2*k+1] = WW'(101 + 2 * k);
    end
    checks++;
    if (beat_cnt !== 4'd3) begin
      errors++;
      $display("FAIL abort_pre_cnt got=%0d want=3", beat_cnt);
    end
    clear = 1'b1;
    bus.in_data = {8'hEE, 8'hEE};
    cyc();
    clear = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (beat_cnt !== 4'd0 || bus.in_ready !== 1'b1 ||
        bus.w_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_state cnt=%0d r=%b v=%b want cnt=0 r=1 v=0",
               beat_cnt, bus.in_ready, bus.w_valid);
    end
    checks++;
    if (bus.w_out !== exp_w) begin
      errors++;
      $display("FAIL abort_w_out got=%h want=%h", bus.w_out, exp_w);
    end
    for (int k = 0; k < 8; k++) begin
      drive_beat(200 + 2 * k);
      cyc();
      exp_w[2*k]   = WW'(200 + 2 * k);
      exp_w[2*k+1] = WW'(201 + 2 * k);
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.w_valid !== 1'b1 || bus.w_out !== exp_w) begin
      errors++;
      $display("FAIL reload got v=%b w=%h want v=1 w=%h",
               bus.w_valid, bus.w_out, exp_w);
    end
  endtask

  task automatic test_clear_handshake();
    clear = 1'b1;
    bus.w_ready = 1'b1;
    cyc();
    clear = 1'b0;
    bus.w_ready = 1'b0;
    checks++;
    if (bus.w_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        beat_cnt !== 4'd0) begin
      errors++;
      $display("FAIL clr_hs v=%b r=%b cnt=%0d want v=0 r=1 cnt=0",
               bus.w_valid, bus.in_ready, beat_cnt);
    end
    checks++;
    if (bus.w_out !== exp_w) begin
      errors++;
      $display("FAIL clr_hs_w_out got=%h want=%h", bus.w_out, exp_w);
    end
  endtask

  task automatic test_reset_mid_fill();
    for (int k = 0; k < 4; k++) begin
      drive_beat(50 + 2 * k);
      cyc();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (beat_cnt !== 4'd4) begin
      errors++;
      $display("FAIL mid_pre_cnt got=%0d want=4", beat_cnt);
    end
    rst_n = 1'b0;
    clear = 1'b1;
    cyc();
    rst_n = 1'b0;
    clear = 1'b0;
    exp_w = '0;
    checks++;
    if (bus.w_out !== exp_w || beat_cnt !== 4'd0 ||
        bus.w_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset w=%h cnt=%0d v=%b want w=0 cnt=0 v=0",
               bus.w_out, beat_cnt, bus.w_valid);
    end
    rst_n = 1'b1;
    drive_beat(9);
    cyc();
    bus.in_valid = 1'b0;
    exp_w[0] = 8'd9;
    exp_w[1] = 8'd10;
    checks++;
    if (beat_cnt !== 4'd1 || bus.w_out !== exp_w) begin
      errors++;
      $display("FAIL first_accept cnt=%0d w=%h want cnt=1 w=%h",
               beat_cnt, bus.w_out, exp_w);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_full_load();
    test_backpressure();
    test_abort();
    test_clear_handshake();
    test_reset_mid_fill();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
